// File: rtl/fml_memtest_master.sv
// FML memory-test initiator: writes a 64-bit Galois LFSR pattern over a range of 4-beat bursts,
// reads the range back and counts mismatching beats. Define FML_MEMTEST_ERRLOG_EN to log the first failing beat.
module fml_memtest_master #(
  parameter int adr_width = 27
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic [63:0]          seed,
  input  logic [adr_width-1:0] base_adr,
  input  logic [15:0]          nbursts,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          err_count,
  output logic                 first_err_valid,
  output logic [adr_width-1:0] first_err_adr,
  output logic [adr_width-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_do,
  input  logic [63:0]          fml_di
);

  // x^64 + x^63 + x^61 + x^60 + 1, left-shifting Galois form
  localparam logic [63:0] LFSR_TAPS = 64'hB000_0000_0000_0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WDATA,
    S_RREQ,
    S_RDATA,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [63:0]          seed_q, seed_d;
  logic [63:0]          lfsr_q, lfsr_d;
  logic [adr_width-1:0] base_q, base_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic [15:0]          nb_q, nb_d;
  logic [15:0]          burst_q, burst_d;
  logic [1:0]           beat_q, beat_d;
  logic [31:0]          err_q, err_d;
  logic                 zero_q, zero_d;

  logic                 last_burst;
  logic                 mismatch;
  logic [adr_width-1:0] base_in;
  logic [adr_width-1:0] adr_next;
  logic [63:0]          seed_in;
  logic [63:0]          lfsr_nx;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], 1'b0} ^ (s[63] ? LFSR_TAPS : 64'h0);
  endfunction

  assign base_in    = base_adr & ~adr_width'(31);
  assign seed_in    = (seed == 64'h0) ? 64'h1 : seed;
  assign lfsr_nx    = lfsr_step(lfsr_q);
  assign adr_next   = adr_q + adr_width'(32);
  assign last_burst = (({1'b0, burst_q} + 17'd1) == {1'b0, nb_q});
  assign mismatch   = (state_q == S_RDATA) && (fml_di != lfsr_q);

  assign fml_sel   = 8'hFF;
  assign fml_adr   = adr_q;
  assign err_count = err_q;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    base_d  = base_q;
    adr_d   = adr_q;
    nb_d    = nb_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    zero_d  = zero_q;
    busy    = 1'b0;
    done    = 1'b0;
    fml_stb = 1'b0;
    fml_we  = 1'b0;
    fml_do  = 64'h0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d  = seed_in;
          lfsr_d  = seed_in;
          base_d  = base_in;
          adr_d   = base_in;
          nb_d    = nbursts;
          burst_d = 16'd0;
          beat_d  = 2'd0;
          err_d   = 32'd0;
          if (nbursts == 16'd0) begin
            zero_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_WREQ;
          end
        end
      end

      S_WREQ: begin
        busy    = 1'b1;
        fml_stb = 1'b1;
        fml_we  = 1'b1;
        if (fml_ack) begin
          beat_d  = 2'd0;
          state_d = S_WDATA;
        end
      end

      S_WDATA: begin
        busy   = 1'b1;
        fml_do = lfsr_q;
        lfsr_d = lfsr_nx;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          if (last_burst) begin
            // read-back regenerates the identical sequence from the seed
            lfsr_d  = seed_q;
            burst_d = 16'd0;
            adr_d   = base_q;
            state_d = S_RREQ;
          end else begin
            burst_d = burst_q + 16'd1;
            adr_d   = adr_next;
            state_d = S_WREQ;
          end
        end
      end

      S_RREQ: begin
        busy    = 1'b1;
        fml_stb = 1'b1;
        if (fml_ack) begin
          beat_d  = 2'd0;
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        busy   = 1'b1;
        lfsr_d = lfsr_nx;
        beat_d = beat_q + 2'd1;
        if (mismatch && (err_q != 32'hFFFF_FFFF)) begin
          err_d = err_q + 32'd1;
        end
        if (beat_q == 2'd3) begin
          if (last_burst) begin
            state_d = S_FIN;
          end else begin
            burst_d = burst_q + 16'd1;
            adr_d   = adr_next;
            state_d = S_RREQ;
          end
        end
      end

      S_FIN: begin
        // an empty run spends one extra busy cycle here so done lands two cycles after start
        if (zero_q) begin
          busy   = 1'b1;
          zero_d = 1'b0;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      seed_q  <= 64'h0;
      lfsr_q  <= 64'h0;
      base_q  <= '0;
      adr_q   <= '0;
      nb_q    <= 16'd0;
      burst_q <= 16'd0;
      beat_q  <= 2'd0;
      err_q   <= 32'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      base_q  <= base_d;
      adr_q   <= adr_d;
      nb_q    <= nb_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

`ifdef FML_MEMTEST_ERRLOG_EN
  logic                 fev_q, fev_d;
  logic [adr_width-1:0] fea_q, fea_d;

  always_comb begin
    fev_d = fev_q;
    fea_d = fea_q;
    if ((state_q == S_IDLE) && start) begin
      fev_d = 1'b0;
      fea_d = '0;
    end else if (mismatch && !fev_q) begin
      fev_d = 1'b1;
      fea_d = adr_q + adr_width'({beat_q, 3'b000});
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      fev_q <= 1'b0;
      fea_q <= '0;
    end else begin
      fev_q <= fev_d;
      fea_q <= fea_d;
    end
  end

  assign first_err_valid = fev_q;
  assign first_err_adr   = fea_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_adr   = '0;
`endif

endmodule

// File: tb/tb_fml_memtest_master.sv
// Bench for fml_memtest_master: table of directed runs against a burst memory model,
// plus hand sequences for empty runs, mid-write reset and error-counter saturation.
module tb_fml_memtest_master;

  localparam int AW      = 27;
  localparam int ACK_DLY = 3;

  logic          sys_clk;
  logic          sys_rst;
  logic          start;
  logic [63:0]   seed;
  logic [AW-1:0] base_adr;
  logic [15:0]   nbursts;
  logic          busy;
  logic          done;
  logic [31:0]   err_count;
  logic          first_err_valid;
  logic [AW-1:0] first_err_adr;
  logic [AW-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_we;
  logic          fml_ack;
  logic [7:0]    fml_sel;
  logic [63:0]   fml_do;
  logic [63:0]   fml_di;

  fml_memtest_master #(.adr_width(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .seed(seed),
    .base_adr(base_adr), .nbursts(nbursts), .busy(busy), .done(done),
    .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_adr(first_err_adr), .fml_adr(fml_adr), .fml_stb(fml_stb),
    .fml_we(fml_we), .fml_ack(fml_ack), .fml_sel(fml_sel), .fml_do(fml_do),
    .fml_di(fml_di)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_nx(input logic [63:0] s);
    return {s[62:0], 1'b0} ^ (s[63] ? 64'hB000_0000_0000_0001 : 64'h0);
  endfunction

  // memory model state
  logic [63:0]   mem [logic [AW-1:0]];
  logic [63:0]   fmask [0:63];
  logic [AW-1:0] req_adr [$];
  bit            req_we [$];
  logic [63:0]   wlog [$];
  int            beats_left, wait_cnt, rd_burst, last_ack, last_rbeat, proto_err, stb_seen;
  logic [AW-1:0] cur_adr, hold_adr;
  bit            cur_we, hold_we, prev_stb;

  task automatic clr_model();
    mem.delete();
    req_adr.delete();
    req_we.delete();
    wlog.delete();
    for (int i = 0; i < 64; i++) fmask[i] = 64'h0;
    rd_burst   = -1;
    last_ack   = -1;
    last_rbeat = -1;
    proto_err  = 0;
    stb_seen   = 0;
  endtask

  initial begin
    int            k, idx;
    logic [AW-1:0] a;
    logic [63:0]   d;
    fml_ack = 1'b0; fml_di = 64'h0; beats_left = 0; wait_cnt = 0; prev_stb = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      fml_ack = 1'b0;
      fml_di  = 64'h0;
      if (sys_rst) begin
        beats_left = 0;
        wait_cnt   = 0;
      end else if (beats_left > 0) begin
        k = 4 - beats_left;
        a = cur_adr + AW'(8 * k);
        if (k == 0 && fml_stb) proto_err++;
        if (cur_we) begin
          mem[a] = fml_do;
          wlog.push_back(fml_do);
        end else begin
          d   = mem.exists(a) ? mem[a] : 64'h0;
          idx = rd_burst * 4 + k;
          if (idx >= 0 && idx < 64) d = d ^ fmask[idx];
          fml_di = d;
          if (k == 3) last_rbeat = cyc;
        end
        beats_left--;
      end else if (fml_stb) begin
        stb_seen++;
        if (!prev_stb && last_ack >= 0 && cyc != last_ack + 5) proto_err++;
        if (wait_cnt == 0) begin
          hold_adr = fml_adr;
          hold_we  = fml_we;
        end else if (fml_adr !== hold_adr || fml_we !== hold_we) begin
          proto_err++;
        end
        if (wait_cnt == ACK_DLY) begin
          fml_ack    = 1'b1;
          cur_adr    = fml_adr;
          cur_we     = fml_we;
          req_adr.push_back(fml_adr);
          req_we.push_back(fml_we);
          if (!fml_we) rd_burst++;
          last_ack   = cyc;
          beats_left = 4;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end
      prev_stb = fml_stb;
    end
  end

  typedef struct {
    logic [63:0]   seed;
    logic [AW-1:0] base;
    logic [15:0]   nb;
    int            fbeat;
    logic [63:0]   fmask;
    bit            mid_start;
    logic [31:0]   exp_err;
    logic [AW-1:0] exp_adr0;
    logic [AW-1:0] exp_adr1;
    logic [63:0]   exp_b0;
    logic [63:0]   exp_b1;
    bit            exp_fev;
    logic [AW-1:0] exp_fea;
  } vec_t;

  task automatic run_test(input vec_t v, input string tag);
    bit            got;
    int            dcyc, extra, bad;
    logic [AW-1:0] b, ea;
    logic [63:0]   s;
    clr_model();
    if (v.fbeat >= 0) fmask[v.fbeat] = v.fmask;
    @(posedge sys_clk); #1;
    seed = v.seed; base_adr = v.base; nbursts = v.nb; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk({tag, ".busy_t1"}, busy, 1);
    chk({tag, ".stb_t1"}, fml_stb, 1);
    got = 1'b0; dcyc = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(posedge sys_clk); #1;
      if (done) begin
        got  = 1'b1;
        dcyc = cyc;
        chk({tag, ".busy_at_done"}, busy, 0);
      end
      if (v.mid_start && c == 8) begin
        start = 1'b1; seed = 64'h55; nbursts = 16'd9; base_adr = 27'h1000;
      end
      if (c == 9) start = 1'b0;
    end
    chk({tag, ".done_seen"}, got, 1);
    chk({tag, ".done_lat"}, dcyc, last_rbeat + 1);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sys_clk); #1;
      if (done) extra++;
    end
    chk({tag, ".one_done"}, extra, 0);
    chk({tag, ".err"}, err_count, v.exp_err);
    chk({tag, ".nreq"}, req_adr.size(), 2 * v.nb);
    if (req_adr.size() > 0) chk({tag, ".adr0"}, req_adr[0], v.exp_adr0);
    if (v.nb >= 2 && req_adr.size() > 1) chk({tag, ".adr1"}, req_adr[1], v.exp_adr1);
    bad = 0;
    b = v.base & ~AW'(31);
    for (int i = 0; i < req_adr.size(); i++) begin
      ea = b + AW'(32 * (i % v.nb));
      if (req_adr[i] !== ea || req_we[i] !== (i < v.nb)) bad++;
    end
    chk({tag, ".req_seq"}, bad, 0);
    chk({tag, ".proto"}, proto_err, 0);
    chk({tag, ".nwbeats"}, wlog.size(), 4 * v.nb);
    if (wlog.size() > 1) begin
      chk({tag, ".beat0"}, wlog[0], v.exp_b0);
      chk({tag, ".beat1"}, wlog[1], v.exp_b1);
    end
    bad = 0;
    s = (v.seed == 64'h0) ? 64'h1 : v.seed;
    for (int j = 0; j < wlog.size(); j++) begin
      if (wlog[j] !== s) bad++;
      s = lfsr_nx(s);
    end
    chk({tag, ".wdata"}, bad, 0);
`ifdef FML_MEMTEST_ERRLOG_EN
    chk({tag, ".fev"}, first_err_valid, v.exp_fev);
    chk({tag, ".fea"}, first_err_adr, v.exp_fea);
`else
    chk({tag, ".fev"}, first_err_valid, 0);
    chk({tag, ".fea"}, first_err_adr, 0);
`endif
  endtask

  vec_t vecs [5];

  initial begin
    bit found;
    vecs[0] = '{64'h1, 27'h0, 16'd4, -1, 64'h0, 1'b0, 32'd0, 27'h0, 27'h20,
                64'h1, 64'h2, 1'b0, 27'h0};
    vecs[1] = '{64'h1, 27'h0, 16'd4, 6, 64'h20, 1'b0, 32'd1, 27'h0, 27'h20,
                64'h1, 64'h2, 1'b1, 27'h30};
    vecs[2] = '{64'h0, 27'h100, 16'd1, -1, 64'h0, 1'b0, 32'd0, 27'h100, 27'h0,
                64'h1, 64'h2, 1'b0, 27'h0};
    vecs[3] = '{64'hDEAD_BEEF_1234_5678, 27'h7FFFFE0, 16'd2, -1, 64'h0, 1'b1, 32'd0,
                27'h7FFFFE0, 27'h0, 64'hDEAD_BEEF_1234_5678, 64'h0D5B_7DDE_2468_ACF1,
                1'b0, 27'h0};
    vecs[4] = '{64'h5, 27'h4F, 16'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'd1,
                27'h40, 27'h60, 64'h5, 64'hA, 1'b1, 27'h40};

    sys_rst = 1'b1; start = 1'b0; seed = 64'h0; base_adr = '0; nbursts = 16'd0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.stb", fml_stb, 0);
    chk("rst.we", fml_we, 0);
    chk("rst.adr", fml_adr, 0);
    chk("rst.do", fml_do, 0);
    chk("rst.err", err_count, 0);
    chk("rst.fev", first_err_valid, 0);
    chk("rst.sel", fml_sel, 8'hFF);
    sys_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_test(vecs[i], $sformatf("v%0d", i));

    // empty run: no traffic, done two cycles after start
    clr_model();
    @(posedge sys_clk); #1;
    seed = 64'h1; base_adr = '0; nbursts = 16'd0; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    chk("zero.busy_t1", busy, 1);
    chk("zero.done_t1", done, 0);
    @(posedge sys_clk); #1;
    chk("zero.done_t2", done, 1);
    chk("zero.busy_t2", busy, 0);
    @(posedge sys_clk); #1;
    chk("zero.done_t3", done, 0);
    chk("zero.no_stb", stb_seen, 0);
    chk("zero.err", err_count, 0);

    // reset during write beat 2
    clr_model();
    @(posedge sys_clk); #1;
    seed = 64'h1; base_adr = '0; nbursts = 16'd2; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(posedge sys_clk); #1;
      if (!fml_stb) found = 1'b1;
    end
    chk("mrst.beat0_seen", found, 1);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("mrst.beat2", fml_do, 64'h4);
    #2 sys_rst = 1'b1;
    #1;
    chk("mrst.stb", fml_stb, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.err", err_count, 0);
    chk("mrst.do", fml_do, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    run_test(vecs[0], "after_rst");

    // saturation: preload near the top, then three mismatching read beats
    clr_model();
    fmask[1] = 64'h1; fmask[2] = 64'h1; fmask[3] = 64'h1;
    @(posedge sys_clk); #1;
    seed = 64'h1; base_adr = '0; nbursts = 16'd1; start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    force dut.err_q = 32'hFFFF_FFFE;
    @(posedge sys_clk); #1;
    release dut.err_q;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge sys_clk); #1;
      if (done) found = 1'b1;
    end
    chk("sat.done_seen", found, 1);
    chk("sat.err", err_count, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
